// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
// Used by led_arbiter and rr_pick.
package led_arb_pkg;

  localparam int N_REQ = 4;
  localparam int LED_W = 10;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

  // Converts a one-hot requester vector into its index; returns 0 for an all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// The search starts just after last_owner and wraps around, so the previous
// owner is considered last.
module rr_pick
  import led_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so that the nearest set request overwrites the others.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last_owner + IDX_W'(k);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Four-way arbiter for the board LED bank with a minimum hold time per owner.
// Optional macro LED_ARB_HEARTBEAT_EN: ledr[9] becomes a free-running heartbeat
// toggling every HOLD_CYC cycles, and owners/IDLE_PAT drive only ledr[8:0].
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int                HOLD_CYC = 25_000_000,
  parameter logic [LED_W-1:0]  IDLE_PAT = 10'h000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] pat,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       ledr,
  output logic                   busy
);

  localparam int               CNT_W   = $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYC - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] winner;
  logic [LED_W-1:0] owner_slice;

  // While owning, last_q always names the current owner, so it doubles as the owner index.
  assign owner_slice = pat[int'(last_q)*LED_W +: LED_W];

  rr_pick u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .winner     (winner)
  );

  // Arbitration state, current grant, last owner and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Re-arbitrate when idle, when the owner lets go, or when its hold time has run out.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          grant_d = winner;
          last_d  = onehot_to_idx(winner);
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (!req[last_q] || cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (|winner) begin
            grant_d = winner;
            last_d  = onehot_to_idx(winner);
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q == OWN);

`ifdef LED_ARB_HEARTBEAT_EN
  logic [CNT_W-1:0] hb_cnt;
  logic             hb;
  logic [LED_W-2:0] led_q;
  logic             unused_owner_msb;

  assign unused_owner_msb = owner_slice[LED_W-1];

  // Free-running heartbeat, independent of arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == CNT_MAX) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  // Lower LED bits follow the owner's pattern, or the idle pattern when nobody owns the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= IDLE_PAT[LED_W-2:0];
    end else if (state_q == OWN) begin
      led_q <= owner_slice[LED_W-2:0];
    end else begin
      led_q <= IDLE_PAT[LED_W-2:0];
    end
  end

  assign ledr = {hb, led_q};
`else
  logic [LED_W-1:0] led_q;

  // All LED bits follow the owner's pattern, or the idle pattern when nobody owns the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= IDLE_PAT;
    end else if (state_q == OWN) begin
      led_q <= owner_slice;
    end else begin
      led_q <= IDLE_PAT;
    end
  end

  assign ledr = led_q;
`endif

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter with HOLD_CYC=8.
// Honours LED_ARB_HEARTBEAT_EN when it is defined for the build.
module tb_led_arbiter;

  localparam int         HOLD     = 8;
  localparam logic [9:0] IDLE_PAT = 10'h2A5;
`ifdef LED_ARB_HEARTBEAT_EN
  localparam logic [9:0] RST_LED  = {1'b0, IDLE_PAT[8:0]};
`else
  localparam logic [9:0] RST_LED  = IDLE_PAT;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = 4'b0;
  logic [39:0] pat   = 40'b0;
  logic [3:0]  grant;
  logic [9:0]  ledr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bank, how long they have held it, what the LEDs show.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_held  = 0;
  int         m_edges = 0;
  logic [9:0] m_led   = IDLE_PAT;

  led_arbiter #(
    .HOLD_CYC (HOLD),
    .IDLE_PAT (IDLE_PAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pat   (pat),
    .grant (grant),
    .ledr  (ledr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  function automatic logic [9:0] exp_ledr();
`ifdef LED_ARB_HEARTBEAT_EN
    return {1'(((m_edges / HOLD) % 2)), m_led[8:0]};
`else
    return m_led;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_edges = 0;
    m_led   = IDLE_PAT;
  endtask

  task automatic model_edge();
    int w;
    m_led = (m_owner < 0) ? IDLE_PAT : pat[m_owner*10 +: 10];
    m_edges++;
    if (m_owner < 0) begin
      w = rr_winner(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 0;
      end
    end else if (!req[m_owner] || m_held == HOLD - 1) begin
      w       = rr_winner(req, m_last);
      m_owner = w;
      if (w >= 0) m_last = w;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endtask

  // Drive inputs mid-cycle, clock once, advance the model, then settle just after the edge.
  task automatic tick(input logic [3:0] r, input logic [39:0] p);
    req = r;
    pat = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [39:0] rand_pat();
    return 40'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ledr !== RST_LED) begin errors++; $display("[TB] FAIL reset_ledr got %h want %h", ledr, RST_LED); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, rand_pat());
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("[TB] FAIL idle_grant got %b/%b want 0000/0", grant, busy);
      end
      checks++;
      if (ledr !== exp_ledr()) begin errors++; $display("[TB] FAIL idle_ledr got %h want %h", ledr, exp_ledr()); end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] cur;
    int         len;
    do_reset();
    tick(4'b1111, rand_pat());
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL rot_first got %b want 0001", grant); end
    cur = 4'b0001;
    len = 1;
    for (int i = 0; i < 40; i++) begin
      tick(4'b1111, rand_pat());
      checks++;
      if (grant !== exp_grant()) begin errors++; $display("[TB] FAIL rot_grant got %b want %b", grant, exp_grant()); end
      checks++;
      if (ledr !== exp_ledr()) begin errors++; $display("[TB] FAIL rot_ledr got %h want %h", ledr, exp_ledr()); end
      if (grant === cur) begin
        len++;
      end else begin
        checks++;
        if (len != HOLD || grant !== {cur[2:0], cur[3]}) begin
          errors++; $display("[TB] FAIL rot_run len %0d next %b want len %0d next %b", len, grant, HOLD, {cur[2:0], cur[3]});
        end
        cur = grant;
        len = 1;
      end
    end
  endtask

  task automatic test_hold_no_preempt();
    logic [39:0] p;
    do_reset();
    p = rand_pat();
    p[29:20] = 10'h2AA;
    tick(4'b0100, p);
    checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_grant got %b/%b want 0100/1", grant, busy); end
    tick(4'b0100, p);
    checks++;
    if (ledr[8:0] !== 9'h0AA) begin errors++; $display("[TB] FAIL hold_ledr got %h want 2aa", ledr); end
    for (int i = 3; i <= 9; i++) begin
      tick((i <= 4) ? 4'b0100 : 4'b0101, p);
      checks++;
      if (grant !== ((i <= 8) ? 4'b0100 : 4'b0001)) begin
        errors++; $display("[TB] FAIL hold_preempt tick %0d got %b want %b", i, grant, (i <= 8) ? 4'b0100 : 4'b0001);
      end
      checks++;
      if (grant !== exp_grant() || ledr !== exp_ledr()) begin
        errors++; $display("[TB] FAIL hold_model got %b/%h want %b/%h", grant, ledr, exp_grant(), exp_ledr());
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'b1010, rand_pat());
      checks++;
      if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL drop_owner got %b want 0010", grant); end
    end
    tick(4'b1000, rand_pat());
    checks++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_handoff got %b/%b want 1000/1", grant, busy); end
    tick(4'b0000, rand_pat());
    tick(4'b0000, rand_pat());
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got %b/%b want 0000/0", grant, busy); end
    checks++;
    if (ledr !== exp_ledr()) begin errors++; $display("[TB] FAIL drop_ledr got %h want %h", ledr, exp_ledr()); end
  endtask

  task automatic test_single_requester();
    logic [39:0] p;
    do_reset();
    p = rand_pat();
    for (int i = 1; i <= 20; i++) begin
      tick(4'b0100, p);
      checks++;
      if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant tick %0d got %b want 0100", i, grant); end
      if (i >= 2) begin
        checks++;
        if (ledr[8:0] !== p[28:20] || ledr !== exp_ledr()) begin
          errors++; $display("[TB] FAIL single_ledr tick %0d got %h want %h", i, ledr, exp_ledr());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) tick(4'b0010, rand_pat());
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL areset_pre got %b want 0010", grant); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_grant got %b/%b want 0000/0", grant, busy); end
    checks++;
    if (ledr !== RST_LED) begin errors++; $display("[TB] FAIL areset_ledr got %h want %h", ledr, RST_LED); end
    model_reset();
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b0011, rand_pat());
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL areset_restart got %b want 0001", grant); end
  endtask

  task automatic test_pattern();
    logic [39:0] p;
    do_reset();
    p = rand_pat();
    p[9:0] = 10'h3FF;
    for (int i = 1; i <= 20; i++) begin
      tick(4'b0001, p);
      if (i >= 2) begin
        checks++;
        if (ledr[8:0] !== 9'h1FF) begin errors++; $display("[TB] FAIL pat_low got %h want 1ff", ledr[8:0]); end
        checks++;
`ifdef LED_ARB_HEARTBEAT_EN
        if (ledr[9] !== 1'(((m_edges / HOLD) % 2))) begin
          errors++; $display("[TB] FAIL pat_heartbeat edge %0d got %b want %b", m_edges, ledr[9], 1'(((m_edges / HOLD) % 2)));
        end
`else
        if (ledr !== 10'h3FF) begin errors++; $display("[TB] FAIL pat_full got %h want 3ff", ledr); end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'($urandom());
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      tick(r, rand_pat());
      checks++;
      if (grant !== exp_grant()) begin errors++; $display("[TB] FAIL rand_grant cyc %0d got %b want %b", i, grant, exp_grant()); end
      checks++;
      if (busy !== (m_owner >= 0)) begin errors++; $display("[TB] FAIL rand_busy cyc %0d got %b want %b", i, busy, m_owner >= 0); end
      checks++;
      if (ledr !== exp_ledr()) begin errors++; $display("[TB] FAIL rand_ledr cyc %0d got %h want %h", i, ledr, exp_ledr()); end
      checks++;
      if ($countones(grant) > 1) begin errors++; $display("[TB] FAIL rand_onehot cyc %0d got %b want at most one bit", i, grant); end
    end
  endtask

  // Scenarios run back to back from a single sequence.
  initial begin
    test_reset();
    test_rotation();
    test_hold_no_preempt();
    test_owner_drop();
    test_single_requester();
    test_async_reset();
    test_pattern();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got no finish want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
